md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the pipelined CPU's execute stage. It owns the HI/LO register pair and serves the multiply, divide and move-to-HI/LO instructions. Multiplies complete after a programmable latency; divides use an iterative restoring divider that retires one quotient bit per cycle. A cancel input lets the exception/interrupt logic abort the operation in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; even, ≥4.
- `MUL_LAT`, 5: multiply busy cycles; ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue the operation on `op` this cycle.
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTLO, 5 MTHI, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; all other codes are no-ops.
- `src_a`  in  WIDTH  rs operand: dividend, multiplicand, or MT data.
- `src_b`  in  WIDTH  rt operand: divisor or multiplier.
- `cancel`  in  1  flush: suppresses `start` and aborts the operation in flight.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse when a result is committed to HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset puts the block in IDLE with `hi`=`lo`=0, `busy`=0, `done`=0 and all internal registers cleared. Reset is honoured mid-operation and discards all work.
- `start` is sampled only in IDLE. While `busy`=1 it is ignored; the pipeline stalls on `busy`.
- `start`&&`cancel` on the same edge: the operation is dropped entirely, including MTHI/MTLO.
- MTLO/MTHI: `lo`/`hi` ← `src_a` at that edge. The block stays in IDLE; `busy` and `done` do not assert.
- MUL ops: latch the operands and op, load a counter with `MUL_LAT`, go to MUL. When the counter expires, compute the full 2·WIDTH product: signed for MULT/MADD/MSUB, unsigned for the U variants.
  - MULT/MULTU: {hi,lo} ← product.
  - MADD*: {hi,lo} ← {hi,lo}+product, modulo 2^(2·WIDTH).
  - MSUB*: {hi,lo} ← {hi,lo}−product, modulo 2^(2·WIDTH).
  - The {hi,lo} used is the value at commit time.
- DIV ops: latch the operand magnitudes (sign-stripped for DIV), then run WIDTH restoring iterations in DIV, then go to FIX.
  - FIX: negate the quotient if the operand signs differ; the remainder takes the dividend's sign. Commit lo ← quotient, hi ← remainder.
  - Divisor 0 (both ops): lo ← all ones, hi ← `src_a` as issued.
  - DIV of most-negative ÷ −1: lo ← most-negative, hi ← 0.
- `cancel` while busy: return to IDLE at the next edge. `hi`/`lo` are unchanged and `done` stays 0.
- Undefined op codes with `start`: no state change.

## Timing
- Issue edge E0. `busy`=1 from the cycle after E0.
- MUL: `busy` stays high for `MUL_LAT` cycles. The result and `busy`→0 both land at edge E`MUL_LAT`. `done`=1 during the following cycle.
- DIV: `busy` stays high for WIDTH+1 cycles (WIDTH iterations plus FIX). The commit lands at edge E(WIDTH+1).
- A new `start` is accepted in the same cycle that `done`=1, i.e. back-to-back issue with no bubble.
- `hi`/`lo` are registered outputs and never change while `busy`=1, except at the commit edge.
- Reset takes effect asynchronously on its falling edge. Release is synchronous to `clk`, and `start` is first sampled on the edge after release.

## Configuration
- `MD_MADD_EN` defined: ops 6–9 are implemented as above, including the 2·WIDTH accumulate adder.
- `MD_MADD_EN` undefined: ops 6–9 decode as no-ops. The accumulate/subtract datapath is not built, and MUL commits the plain product only.

## Structure
- Package `md_pkg`:
  - op-code enum `md_op_e`
  - state enum `md_state_e`
  - helper function `md_is_signed(op)`
- Sub-module `md_divider`: unsigned restoring core with WIDTH-bit dividend/divisor magnitudes. Ports: `load`, `step`, `quotient`, `remainder`, `last`. It handles no signs.
- Top level `md_unit` holds:
  - the FSM
  - the MUL counter
  - operand latches
  - sign fix-up
  - the MADD/MSUB adder
  - the HI/LO registers

## Test plan
- Reset low mid-DIV (cycle 10) → `hi`=`lo`=0 and `busy`=0 immediately. After release, MTLO 0x1234 gives `lo`=0x1234 on the next edge.
- MULT −3 × 7, `MUL_LAT`=5 → `busy` for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, and a `done` pulse. MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE.
- DIV −7 ÷ 2 → after 33 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=7.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU issued, `cancel` at busy cycle 12 → `busy`=0 next cycle, `hi`/`lo` keep their prior values, no `done`. `start`+`cancel` with MTHI → `hi` unchanged.
- `MD_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, then MADDU 1×1 → `hi`=1, `lo`=0. MSUB 1×1 → `hi`=0, `lo`=0xFFFFFFFF. Without the macro, op 6 → no change.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTLO  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Ops whose operands are interpreted as two's complement.
    function automatic logic md_is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_divider.sv
// Unsigned restoring divider core: one quotient bit per step, no sign handling.
module md_divider
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] divisor_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_q};

    // last is high during the cycle in which the final step is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            last      <= 1'b0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
            cnt_q     <= '0;
            last      <= 1'b0;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
            last  <= (cnt_q == CW'(WIDTH - 2));
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; define MD_MADD_EN to build the MADD/MSUB accumulate ops.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(MUL_LAT + 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    md_op_e           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             quo_neg_q, rem_neg_q, bzero_q;

    logic [WIDTH-1:0] hi_d, lo_d;
    logic             done_d;
    logic             latch_en;
    logic             div_load, div_step;

    md_op_e           op_e;
    logic             sgn, a_neg, b_neg;
    logic             is_mul, is_div;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH-1:0] quotient, remainder;
    logic             div_last;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    logic [DW-1:0]    ext_a, ext_b, product, acc;

    // Issue-side decode and operand magnitude extraction.
    assign op_e  = md_op_e'(op);
    assign sgn   = md_is_signed(op_e);
    assign a_neg = sgn & src_a[WIDTH-1];
    assign b_neg = sgn & src_b[WIDTH-1];
    assign mag_a = a_neg ? (WIDTH'(0) - src_a) : src_a;
    assign mag_b = b_neg ? (WIDTH'(0) - src_b) : src_b;
    assign is_div = md_is_div(op_e);

`ifdef MD_MADD_EN
    assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU) ||
                    (op_e == OP_MADD) || (op_e == OP_MADDU) ||
                    (op_e == OP_MSUB) || (op_e == OP_MSUBU);
`else
    assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU);
`endif

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (div_last)
    );

    // Full-width product; extension choice makes one multiplier serve both signednesses.
    assign ext_a   = md_is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b   = md_is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = ext_a * ext_b;

`ifdef MD_MADD_EN
    // Accumulate against HI/LO as they stand at commit.
    always_comb begin
        acc = product;
        case (op_q)
            OP_MADD, OP_MADDU: acc = {hi, lo} + product;
            OP_MSUB, OP_MSUBU: acc = {hi, lo} - product;
            default:           acc = product;
        endcase
    end
`else
    assign acc = product;
`endif

    assign quo_fix = quo_neg_q ? (WIDTH'(0) - quotient)  : quotient;
    assign rem_fix = rem_neg_q ? (WIDTH'(0) - remainder) : remainder;

    // Next-state and commit logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi;
        lo_d     = lo;
        done_d   = 1'b0;
        latch_en = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (op_e == OP_MTLO) begin
                        lo_d = src_a;
                    end else if (op_e == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (is_mul) begin
                        latch_en = 1'b1;
                        cnt_d    = CW'(MUL_LAT);
                        state_d  = ST_MUL;
                    end else if (is_div) begin
                        latch_en = 1'b1;
                        div_load = 1'b1;
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    {hi_d, lo_d} = acc;
                    done_d       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_last) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    if (bzero_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi      <= hi_d;
            lo      <= lo_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            if (latch_en) begin
                op_q      <= op_e;
                a_q       <= src_a;
                b_q       <= src_b;
                quo_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                bzero_q   <= (src_b == '0);
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_md_unit;

    localparam int W    = 32;
    localparam int LAT  = 5;
    localparam int DLAT = W + 1;

`ifdef MD_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op from plain integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output int lat);
        logic [63:0] p;
        logic [63:0] acc;
        longint      sa, sb;
        int          da, db;
        lat = 0;
        acc = {h, l};
        p   = '0;
        case (o)
            4'd4: l = a;
            4'd5: h = a;
            4'd0, 4'd1, 4'd6, 4'd7, 4'd8, 4'd9: begin
                if (o <= 4'd1 || MADD_ON) begin
                    if (o == 4'd0 || o == 4'd6 || o == 4'd8) begin
                        sa = $signed(a);
                        sb = $signed(b);
                        p  = sa * sb;
                    end else begin
                        p = {32'd0, a} * {32'd0, b};
                    end
                    if (o == 4'd6 || o == 4'd7)      acc = acc + p;
                    else if (o == 4'd8 || o == 4'd9) acc = acc - p;
                    else                             acc = p;
                    {h, l} = acc;
                    lat = LAT;
                end
            end
            4'd2: begin
                da = $signed(a);
                db = $signed(b);
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    l = da / db;
                    h = da % db;
                end
                lat = DLAT;
            end
            4'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
                lat = DLAT;
            end
            default: ;
        endcase
    endfunction

    // Issue one op from #1 after an edge, follow it to completion and check the result.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int elat, input string name);
        int n;
        bit busy_ok;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (elat == 0) begin
            chk({name, " busy/done"}, 64'({busy, done}), 64'd0);
        end else begin
            n       = 0;
            busy_ok = 1'b1;
            while (!done && n < 200) begin
                if (!busy) busy_ok = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
            chk({name, " latency"}, 64'(n), 64'(elat));
            chk({name, " busy held"}, 64'(busy_ok), 64'd1);
            chk({name, " busy at done"}, 64'(busy), 64'd0);
        end
        chk({name, " hi:lo"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        int  lat;
        bit  seen_done;
        logic [3:0]  o;
        logic [31:0] a, b, eh, el;
        logic [3:0]  ops[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd15};

        #1;
        chk("reset hi:lo", {hi, lo}, 64'd0);
        chk("reset busy/done", 64'({busy, done}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        vq.push_back('{4'd4,  32'h0000_1234, 32'd0,         32'h0000_0000, 32'h0000_1234, 0});
        vq.push_back('{4'd0,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT});
        vq.push_back('{4'd1,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, LAT});
        vq.push_back('{4'd2,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT});
        vq.push_back('{4'd3,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, DLAT});
        vq.push_back('{4'd2,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DLAT});
        vq.push_back('{4'd2,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, DLAT});
        vq.push_back('{4'd5,  32'h0000_ABCD, 32'd0,         32'h0000_ABCD, 32'hFFFF_FFF2, 0});
        vq.push_back('{4'd12, 32'h5A5A_5A5A, 32'd3,         32'h0000_ABCD, 32'hFFFF_FFF2, 0});
`ifdef MD_MADD_EN
        vq.push_back('{4'd5,  32'd0,         32'd0,         32'h0000_0000, 32'hFFFF_FFF2, 0});
        vq.push_back('{4'd4,  32'hFFFF_FFFF, 32'd0,         32'h0000_0000, 32'hFFFF_FFFF, 0});
        vq.push_back('{4'd7,  32'd1,         32'd1,         32'h0000_0001, 32'h0000_0000, LAT});
        vq.push_back('{4'd8,  32'd1,         32'd1,         32'h0000_0000, 32'hFFFF_FFFF, LAT});
        vq.push_back('{4'd6,  32'hFFFF_FFFE, 32'd3,         32'h0000_0000, 32'hFFFF_FFF9, LAT});
`else
        vq.push_back('{4'd6,  32'd1,         32'd1,         32'h0000_ABCD, 32'hFFFF_FFF2, 0});
`endif

        foreach (vq[i]) begin
            run(vq[i].op, vq[i].a, vq[i].b, vq[i].exp_hi, vq[i].exp_lo, vq[i].lat,
                $sformatf("vec%0d", i));
            m_hi = vq[i].exp_hi;
            m_lo = vq[i].exp_lo;
        end

        // Random back-to-back ops against the model.
        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(11, 0)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(5, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(9, 1));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(1000, 0));
                default: ;
            endcase
            model(o, a, b, m_hi, m_lo, lat);
            run(o, a, b, m_hi, m_lo, lat, $sformatf("rand%0d op%0d", i, o));
        end

        // Reset asserted mid-divide clears everything immediately.
        run(4'd5, 32'h5555_0000, 32'd0, 32'h5555_0000, m_lo, 0, "pre-reset mthi");
        op = 4'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset hi:lo", {hi, lo}, 64'd0);
        chk("async reset busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(4'd4, 32'h0000_1234, 32'd0, 32'd0, 32'h0000_1234, 0, "mtlo after reset");

        // Cancel at busy cycle 12 of a DIVU.
        run(4'd5, 32'h1111_1111, 32'd0, 32'h1111_1111, 32'h0000_1234, 0, "mthi setup");
        run(4'd4, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, 0, "mtlo setup");
        op = 4'd3; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("cancel busy before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel busy after", 64'(busy), 64'd0);
        chk("cancel hi:lo", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        seen_done = done;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen_done |= done | busy;
        end
        chk("cancel no done", 64'(seen_done), 64'd0);

        // start with cancel on the same edge drops even MTHI and MULT.
        op = 4'd5; src_a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        chk("start+cancel mthi", {hi, lo}, {32'h1111_1111, 32'h2222_2222});
        op = 4'd0; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        chk("start+cancel mult busy", 64'(busy), 64'd0);

        // Cancel during MUL leaves HI/LO alone.
        op = 4'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("mul cancel", {31'd0, busy, hi, lo}, {32'd0, 32'h1111_1111, 32'h2222_2222});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
